// File: rtl/pr_ctrl_pkg.sv
// pr_ctrl_pkg: shared types and constants for the partial-reconfiguration
// sequencer.
//   pr_state_t   - sequencer states
//   ST_*         - status codes driven by the PR IP on pr_status
//   ERR_*        - err_code values (IP fault codes reused as-is)
//   is_ip_fault  - true for the IP status codes that abort a reconfiguration
//   max_u        - helper used to size the shared timer
package pr_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FREEZE    = 3'd1,
    S_START     = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RELEASE   = 3'd5,
    S_FAIL      = 3'd6
  } pr_state_t;

  // PR IP status encodings
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_ERR      = 3'b001;
  localparam logic [2:0] ST_CRC      = 3'b010;
  localparam logic [2:0] ST_INCOMPAT = 3'b011;
  localparam logic [2:0] ST_BUSY     = 3'b100;
  localparam logic [2:0] ST_OK       = 3'b101;

  // Error codes; 001..011 mirror the IP fault status directly
  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_IP       = 3'b001;
  localparam logic [2:0] ERR_CRC      = 3'b010;
  localparam logic [2:0] ERR_INCOMPAT = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b110;
  localparam logic [2:0] ERR_LEN      = 3'b111;

  function automatic logic is_ip_fault(input logic [2:0] st);
    return (st == ST_ERR) || (st == ST_CRC) || (st == ST_INCOMPAT);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pr_ctrl_timer.sv
// pr_ctrl_timer: loadable down-counter shared by the settle and timeout
// phases of the sequencer. Loading N-1 makes expired assert on the N-th
// cycle after the load.
//   clk, n_rst  - clock, asynchronous active-low reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - value to load
//   expired     - counter is at zero
module pr_ctrl_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pr_ctrl.sv
// pr_ctrl: sequencer for one partial-reconfiguration region. Freezes the
// region, starts the PR IP, streams the bitstream from a valid/ready source
// into the IP, waits for the IP verdict and then releases the region
// (success) or keeps it frozen and flags an error (failure).
// Ports:
//   clk, n_rst        - clock, asynchronous active-low reset
//   req, req_len      - start pulse and word count (sampled in IDLE/FAIL)
//   src_data/valid    - bitstream source; src_ready back to the source
//   pr_data/valid     - combinational pass-through to the PR IP
//   pr_data_ready     - PR IP data ready
//   pr_status         - PR IP status
//   pr_start          - PR IP start (registered)
//   freeze            - region freeze (registered)
//   busy, done, error - registered status; done is a one-cycle pulse
//   err_code          - cause of the last failure, held until next accepted req
module pr_ctrl
  import pr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned LEN_W       = 20,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] pr_data,
  output logic              pr_data_valid,
  input  logic              pr_data_ready,
  input  logic [2:0]        pr_status,
  output logic              pr_start,
  output logic              freeze,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam int unsigned TMR_MAX = max_u(SETTLE_CYC, TIMEOUT_CYC);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYC - 1);

  pr_state_t          state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   word_cnt;
  logic [2:0]         err_nxt;
  logic               accept;
  logic               in_stream;
  logic               xfer;
  logic               last_xfer;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               tmr_expired;

  // ---------------------------------------------------------------------------
  // Handshake path: purely combinational, gated by the STREAM state only
  // ---------------------------------------------------------------------------
  assign in_stream     = (state == S_STREAM);
  assign pr_data       = src_data;
  assign src_ready     = in_stream & pr_data_ready;
  assign pr_data_valid = in_stream & src_valid;
  assign xfer          = in_stream & src_valid & pr_data_ready;
  assign last_xfer     = xfer && (word_cnt == (len_q - 1'b1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    accept    = 1'b0;

    case (state)
      S_IDLE, S_FAIL: begin
        if (req) begin
          if (req_len != '0) begin
            state_nxt = S_FREEZE;
            err_nxt   = ERR_NONE;
            accept    = 1'b1;
          end else begin
            state_nxt = S_FAIL;
            err_nxt   = ERR_LEN;
          end
        end
      end

      S_FREEZE: begin
        if (tmr_expired) state_nxt = S_START;
      end

      S_START: begin
        // IP acceptance wins over a timeout landing in the same cycle
        if (pr_status == ST_BUSY) begin
          state_nxt = S_STREAM;
        end else if (tmr_expired) begin
          state_nxt = S_FAIL;
          err_nxt   = ERR_TIMEOUT;
        end
      end

      S_STREAM: begin
        if (is_ip_fault(pr_status)) begin
          state_nxt = S_FAIL;
          err_nxt   = pr_status;
        end else if (last_xfer) begin
          state_nxt = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (pr_status == ST_OK) begin
          state_nxt = S_RELEASE;
        end else if (is_ip_fault(pr_status)) begin
          state_nxt = S_FAIL;
          err_nxt   = pr_status;
        end else if (tmr_expired) begin
          state_nxt = S_FAIL;
          err_nxt   = ERR_TIMEOUT;
        end
      end

      S_RELEASE: begin
        if (tmr_expired) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared timer: reloaded on every state change with the budget of the
  // state being entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    tmr_load     = (state_nxt != state);
    tmr_load_val = '0;
    case (state_nxt)
      S_FREEZE, S_RELEASE:  tmr_load_val = SETTLE_LD;
      S_START, S_WAIT_DONE: tmr_load_val = TIMEOUT_LD;
      default:              tmr_load_val = '0;
    endcase
  end

  pr_ctrl_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // ---------------------------------------------------------------------------
  // State, request capture and word counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_nxt;
      err_code <= err_nxt;
      if (accept) begin
        len_q    <= req_len;
        word_cnt <= '0;
      end else if (xfer) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered control outputs, derived from the next state so they line up
  // with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pr_start <= 1'b0;
      freeze   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      pr_start <= (state_nxt == S_START);
      busy     <= !(state_nxt inside {S_IDLE, S_FAIL});
      error    <= (state_nxt == S_FAIL);
      done     <= (state == S_RELEASE) && (state_nxt == S_IDLE);
      // freeze is held across FAIL so a length error before any freeze
      // leaves the region unfrozen, while a failed reconfiguration keeps it
      // frozen; only a completed RELEASE drops it.
      if (state_nxt == S_FREEZE) begin
        freeze <= 1'b1;
      end else if (state_nxt == S_IDLE) begin
        freeze <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pr_ctrl.sv
// tb_pr_ctrl: self-checking bench for pr_ctrl. A behavioural PR IP and a
// bitstream source live in the bench; expected timing and data are derived
// from request time, IP response times and the sent word list.
module tb_pr_ctrl;

  localparam int DW     = 16;
  localparam int LW     = 20;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  localparam logic [2:0] P_IDLE = 3'b000;
  localparam logic [2:0] P_CRC  = 3'b010;
  localparam logic [2:0] P_BUSY = 3'b100;
  localparam logic [2:0] P_OK   = 3'b101;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          req;
  logic [LW-1:0] req_len;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] pr_data;
  logic          pr_data_valid;
  logic          pr_data_ready;
  logic [2:0]    pr_status;
  logic          pr_start;
  logic          freeze;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    err_code;

  always #5 clk = ~clk;

  pr_ctrl #(
    .DATA_W      (DW),
    .LEN_W       (LW),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .req           (req),
    .req_len       (req_len),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .pr_data       (pr_data),
    .pr_data_valid (pr_data_valid),
    .pr_data_ready (pr_data_ready),
    .pr_status     (pr_status),
    .pr_start      (pr_start),
    .freeze        (freeze),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  logic [DW-1:0] words[$];
  logic [DW-1:0] rx[$];
  int            src_idx;
  int            exp_len;
  bit            gapped, toggle;

  // IP model: 0 idle, 1 counting to busy, 2 receiving, 3 deciding, 4 reported
  int            ip_state, ip_cnt, busy_delay, resp_delay;
  bit            ip_never;
  logic [2:0]    ip_result, ip_status_nxt;
  bit            prev_busy, prev_error;

  int t_req, t_ps, pstart_cnt, done_cnt, t_done, t_res, t_err, t_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_inputs();
    pr_status     = ip_status_nxt;
    pr_data_ready = toggle ? ~pr_data_ready : 1'b1;
    if (src_idx < words.size()) begin
      src_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
      src_data  = words[src_idx];
    end else begin
      src_valid = 1'b0;
      src_data  = DW'($urandom);
    end
  endtask

  // Evaluate one cycle at the falling edge, then advance the models.
  task automatic sample();
    bit win;
    // streaming is legal once the IP showed BUSY in an earlier cycle and
    // words remain outstanding
    win = prev_busy && (rx.size() < exp_len) && (n_rst === 1'b1);
    check("src_ready", 32'(src_ready), 32'(pr_data_ready & win));
    check("pr_data_valid", 32'(pr_data_valid), 32'(src_valid & win));
    if (pr_data_valid === 1'b1) check("pr_data", 32'(pr_data), 32'(src_data));
    if (pr_data_valid === 1'b1 && pr_data_ready === 1'b1) begin
      rx.push_back(pr_data);
      if (ip_state == 2 && rx.size() == exp_len) begin
        ip_state = 3;
        t_last   = cyc;
      end
    end
    if (src_valid === 1'b1 && src_ready === 1'b1) src_idx++;
    if (pr_start === 1'b1) begin
      if (pstart_cnt == 0) t_ps = cyc;
      pstart_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      t_done = cyc;
    end
    if (error === 1'b1 && !prev_error && t_err < 0) t_err = cyc;
    prev_error = (error === 1'b1);
    if (ip_state == 0 && !ip_never && pr_start === 1'b1) begin
      ip_cnt   = 1;
      ip_state = 1;
    end else if (ip_state == 1) begin
      ip_cnt++;
    end
    if (ip_state == 1 && ip_cnt == busy_delay) begin
      ip_state      = 2;
      ip_status_nxt = P_BUSY;
    end
    if (ip_state == 3 && cyc >= t_last + resp_delay) begin
      ip_state      = 4;
      ip_status_nxt = ip_result;
      t_res         = cyc + 1;
    end
    prev_busy = (pr_status === P_BUSY);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic start_req(input int len, input bit gp, input bit tg, input logic [2:0] res,
                           input bit never, input int bd, input int rd);
    words.delete();
    rx.delete();
    src_idx = 0;
    for (int i = 0; i < len; i++) words.push_back(DW'($urandom));
    exp_len = len; gapped = gp; toggle = tg; ip_result = res; ip_never = never;
    busy_delay = bd; resp_delay = rd;
    ip_state = 0; ip_cnt = 0; ip_status_nxt = P_IDLE;
    t_ps = -1; pstart_cnt = 0; done_cnt = 0; t_done = -1; t_res = -1; t_err = -1; t_last = -1;
    drive_inputs();
    req     = 1'b1;
    req_len = LW'(len);
    t_req   = cyc;
    tick();
    req     = 1'b0;
    req_len = LW'($urandom);
    if (len != 0) begin
      check("acc_busy", 32'(busy), 32'd1);
      check("acc_freeze", 32'(freeze), 32'd1);
      check("acc_error", 32'(error), 32'd0);
    end else begin
      check("zl_error", 32'(error), 32'd1);
      check("zl_code", 32'(err_code), 32'h7);
      check("zl_busy", 32'(busy), 32'd0);
    end
  endtask

  task automatic run_until_end(input string tag, input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && t_err < 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_bound"}, 32'(n < max_cyc), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwords"}, 32'(rx.size()), 32'(exp_len));
    for (int i = 0; i < exp_len; i++)
      if (i < rx.size()) check({tag, "_word"}, 32'(rx[i]), 32'(words[i]));
  endtask

  task automatic check_success(input string tag);
    check({tag, "_pstart_t"}, 32'(t_ps), 32'(t_req + 1 + SETTLE));
    check({tag, "_pstart_n"}, 32'(pstart_cnt), 32'(busy_delay + 1));
    check_words(tag);
    check({tag, "_done_n"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_t"}, 32'(t_done), 32'(t_res + SETTLE + 1));
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_freeze"}, 32'(freeze), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_freeze"}, 32'(freeze), 32'd0);
    check({tag, "_pstart"}, 32'(pr_start), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_code"}, 32'(err_code), 32'd0);
    check({tag, "_src_ready"}, 32'(src_ready), 32'd0);
    check({tag, "_pr_valid"}, 32'(pr_data_valid), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; req = 1'b0; req_len = '0; src_data = '0; src_valid = 1'b0;
    pr_data_ready = 1'b1; pr_status = P_IDLE;
    exp_len = 0; gapped = 0; toggle = 0; src_idx = 0;
    ip_state = 0; ip_cnt = 0; ip_never = 0; busy_delay = 3; resp_delay = 1;
    ip_result = P_OK; ip_status_nxt = P_IDLE; prev_busy = 0; prev_error = 0;
    t_req = 0; t_ps = -1; pstart_cnt = 0; done_cnt = 0; t_done = -1; t_res = -1;
    t_err = -1; t_last = -1;

    #1;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    tick();

    // zero length from IDLE: region never frozen; repeat from FAIL holds
    start_req(0, 0, 0, P_OK, 0, 3, 0);
    check("zl_freeze", 32'(freeze), 32'd0);
    tick();
    start_req(0, 0, 0, P_OK, 0, 3, 0);
    check("zl2_freeze", 32'(freeze), 32'd0);

    // plain success, 4 words
    start_req(4, 0, 0, P_OK, 0, 3, 2);
    run_until_end("ok4", 300);
    check_success("ok4");

    // backpressure with gapped source; a req while busy must be ignored
    start_req(3, 1, 1, P_OK, 0, $urandom_range(1, 4), $urandom_range(0, 3));
    req = 1'b1; req_len = '0;
    tick();
    req = 1'b0;
    check("ign_error", 32'(error), 32'd0);
    check("ign_busy", 32'(busy), 32'd1);
    run_until_end("bp3", 300);
    check_success("bp3");

    // CRC failure reported in WAIT_DONE, then a clean 2-word run
    start_req($urandom_range(2, 6), 1, 0, P_CRC, 0, 2, 1);
    run_until_end("crc", 300);
    check_words("crc");
    check("crc_error", 32'(error), 32'd1);
    check("crc_code", 32'(err_code), 32'h2);
    check("crc_freeze", 32'(freeze), 32'd1);
    check("crc_busy", 32'(busy), 32'd0);
    check("crc_done", 32'(done_cnt), 32'd0);
    start_req(2, 0, 0, P_OK, 0, 3, 0);
    run_until_end("rec2", 300);
    check_success("rec2");

    // IP never answers: timeout in START
    start_req(3, 0, 0, P_OK, 1, 3, 0);
    run_until_end("tmo", SETTLE + TMO + 50);
    check("tmo_t", 32'(t_err), 32'(t_ps + TMO));
    check("tmo_pstart_n", 32'(pstart_cnt), 32'(TMO));
    check("tmo_code", 32'(err_code), 32'h6);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_pstart", 32'(pr_start), 32'd0);
    check("tmo_freeze", 32'(freeze), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);

    // reset after 2 of 5 words
    start_req(5, 0, 0, P_OK, 0, 3, 1);
    begin
      int n = 0;
      while (rx.size() < 2 && n < 200) begin
        tick();
        n++;
      end
      check("mid_bound", 32'(n < 200), 32'd1);
    end
    check("mid_busy_pre", 32'(busy), 32'd1);
    n_rst = 1'b0;
    ip_state = 0; ip_status_nxt = P_IDLE; pr_status = P_IDLE; prev_busy = 0;
    exp_len = 0; words.delete(); src_idx = 0;
    #1;
    check_reset_vals("mid");
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    start_req(5, 0, 0, P_OK, 0, 3, 1);
    run_until_end("post5", 300);
    check_success("post5");

    // randomized successful runs
    for (int r = 0; r < 4; r++) begin
      start_req($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                P_OK, 0, $urandom_range(1, 4), $urandom_range(0, 3));
      run_until_end("rnd", 300);
      check_success("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
